maj9_bist_ctrl: RTL
===================

MAJ9_BIST_CTRL -- requirements
Module: maj9_bist_ctrl

Interface
REQ-001 SHALL expose parameter N, default 9: DUT input width.
REQ-002 SHALL expose parameter THRESH, default 5: reference majority threshold, ref = popcount(x) >= THRESH.
REQ-003 SHALL expose parameter SETTLE, default 1: extra hold cycles per pattern before sampling, range 0..15.
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 Ports SHALL be:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  run request, sampled in IDLE or DONE only.
- dut_x  out  N  pattern driven to the DUT under test.
- dut_y  in  1  DUT majority output.
- busy  out  1  high while a run is in progress.
- done  out  1  high from run completion until the next start or reset.
- pass  out  1  valid while done is high; 1 iff err_count == 0.
- err_count  out  N+1  mismatching patterns in the current or last run.
- first_fail_x  out  N  first mismatching pattern.
- first_fail_valid  out  1  first_fail_x holds a captured pattern.

Function
REQ-006 The FSM SHALL have exactly four states: IDLE, SETTLE, CHECK and DONE.
REQ-007 IDLE or DONE with start=1 at an edge SHALL go to SETTLE and clear dut_x, err_count, first_fail_valid, done, pass, and the settle counter.
REQ-008 In SETTLE, the settle counter SHALL increment each cycle; the FSM SHALL move to CHECK at the edge where counter == SETTLE-1; if SETTLE=0, start SHALL go directly to CHECK.
REQ-009 At the edge ending a CHECK cycle, the block SHALL sample dut_y and compare it with ref(dut_x).
REQ-010 On a CHECK mismatch, the block SHALL increment err_count by 1 (N+1 bits, no saturation needed).
REQ-011 On a CHECK mismatch with first_fail_valid=0, the block SHALL load first_fail_x <= dut_x and set first_fail_valid.
REQ-012 In CHECK with dut_x != 2^N-1, the block SHALL increment dut_x and go to SETTLE (or stay in CHECK if SETTLE=0).
REQ-013 In CHECK with dut_x == 2^N-1, the block SHALL go to DONE; dut_x SHALL NOT wrap and SHALL hold 2^N-1.
REQ-014 Each pattern SHALL be held stable for exactly SETTLE+1 cycles.
REQ-015 done SHALL rise exactly 2^N*(SETTLE+1) edges after the start edge (1024 for the default parameters).
REQ-016 busy SHALL equal (state is SETTLE or CHECK).
REQ-017 done SHALL equal (state == DONE).
REQ-018 pass SHALL be registered together with the entry to DONE.
REQ-019 start while busy SHALL be ignored.
REQ-020 start held high across DONE SHALL restart on the next edge, with done low for at least one run.
REQ-021 The mismatch from the final pattern SHALL be reflected in err_count and pass on the same edge that sets done.
REQ-022 All outputs SHALL be registered; dut_y SHALL be the only combinational input to the next-state logic of err_count and first_fail_x.

Reset
REQ-023 rst_n low SHALL immediately force state=IDLE, dut_x=0, err_count=0, first_fail_x=0, first_fail_valid=0, busy=0, done=0, pass=0.
REQ-024 Reset asserted mid-run SHALL abort the run with no partial result retained.
REQ-025 After reset release, the block SHALL wait in IDLE for start.

Structure
REQ-026 Package maj_pkg SHALL hold the N, THRESH and SETTLE defaults, the state enum typedef, and a popcount function.
REQ-027 The reference comparison SHALL be a separate combinational sub-module maj_ref (inputs x[N-1:0]; output y = popcount(x) >= THRESH), reusable by other BIST variants.
REQ-028 maj9_bist_ctrl SHALL contain only the FSM, the pattern counter, the settle counter and the result registers.

Verification
REQ-029 Correct majority model on dut_y, start pulse -> done after 1024 cycles, err_count=0, pass=1, first_fail_valid=0.
REQ-030 dut_y stuck at 0 -> err_count=256, first_fail_x=9'h01F, pass=0.
REQ-031 dut_y = inverted majority -> err_count=512, first_fail_x=9'h000.
REQ-032 Model with threshold 4 -> err_count=126, first_fail_x=9'h00F.
REQ-033 Reset mid-run at pattern 9'h080 -> all outputs zero immediately, state IDLE; a fresh start then completes with the correct count.
REQ-034 start pulses while busy, SETTLE=0 variant, and restart from DONE -> pulses ignored, done at 512 cycles, counters cleared at restart.

Source files
------------

// File: rtl/maj_pkg.sv
// Shared defaults, FSM state type and popcount helper
// for the majority-gate BIST controllers.
package maj_pkg;

    localparam int MAJ_N      = 9;
    localparam int MAJ_THRESH = 5;
    localparam int MAJ_SETTLE = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic int popcount(input logic [31:0] v);
        int c;
        c = 0;
        for (int i = 0; i < 32; i++) begin
            c += int'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/maj_ref.sv
// Combinational reference majority: y = popcount(x) >= THRESH.
// Kept standalone so other BIST variants can reuse it.
module maj_ref
    import maj_pkg::*;
#(
    parameter int N      = MAJ_N,
    parameter int THRESH = MAJ_THRESH
) (
    input  logic [N-1:0] x,
    output logic         y
);

    assign y = (popcount(32'(x)) >= THRESH);

endmodule

// File: rtl/maj9_bist_ctrl.sv
// Exhaustive BIST controller for an N-input majority gate:
// sweeps every pattern, compares dut_y to the reference, tallies errors.
module maj9_bist_ctrl
    import maj_pkg::*;
#(
    parameter int N      = MAJ_N,
    parameter int THRESH = MAJ_THRESH,
    parameter int SETTLE = MAJ_SETTLE
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic [N-1:0] dut_x,
    input  logic         dut_y,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   err_count,
    output logic [N-1:0] first_fail_x,
    output logic         first_fail_valid
);

    localparam logic [3:0] LP_LAST  = 4'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam state_t     LP_FIRST = (SETTLE == 0) ? ST_CHECK : ST_SETTLE;
    localparam logic [N-1:0] LP_ONE_X = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N:0]   LP_ONE_E = {{N{1'b0}}, 1'b1};

    state_t       r_state;
    logic [N-1:0] r_x;
    logic [3:0]   r_cnt;
    logic [N:0]   r_err;
    logic [N-1:0] r_ff;
    logic         r_ffv;
    logic         r_pass;
    logic         r_busy;
    logic         r_done;

    state_t       w_state_n;
    logic [N-1:0] w_x_n;
    logic [3:0]   w_cnt_n;
    logic [N:0]   w_err_n;
    logic [N-1:0] w_ff_n;
    logic         w_ffv_n;
    logic         w_pass_n;
    logic         w_ref;
    logic         w_mis;

    maj_ref #(
        .N      (N),
        .THRESH (THRESH)
    ) u_ref (
        .x (r_x),
        .y (w_ref)
    );

    assign w_mis = (dut_y != w_ref);

    always_comb begin
        w_state_n = r_state;
        w_x_n     = r_x;
        w_cnt_n   = r_cnt;
        w_err_n   = r_err;
        w_ff_n    = r_ff;
        w_ffv_n   = r_ffv;
        w_pass_n  = r_pass;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_n = LP_FIRST;
                    w_x_n     = '0;
                    w_cnt_n   = '0;
                    w_err_n   = '0;
                    w_ffv_n   = 1'b0;
                    w_pass_n  = 1'b0;
                end
            end
            ST_SETTLE: begin
                w_cnt_n = r_cnt + 4'd1;
                if (r_cnt == LP_LAST) begin
                    w_state_n = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (w_mis) begin
                    w_err_n = r_err + LP_ONE_E;
                    if (!r_ffv) begin
                        w_ff_n  = r_x;
                        w_ffv_n = 1'b1;
                    end
                end
                // last pattern holds at all-ones; pass sees its own mismatch
                if (r_x == '1) begin
                    w_state_n = ST_DONE;
                    w_pass_n  = (w_err_n == '0);
                end else begin
                    w_x_n     = r_x + LP_ONE_X;
                    w_cnt_n   = '0;
                    w_state_n = LP_FIRST;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_x     <= '0;
            r_cnt   <= '0;
            r_err   <= '0;
            r_ff    <= '0;
            r_ffv   <= 1'b0;
            r_pass  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_x     <= w_x_n;
            r_cnt   <= w_cnt_n;
            r_err   <= w_err_n;
            r_ff    <= w_ff_n;
            r_ffv   <= w_ffv_n;
            r_pass  <= w_pass_n;
            r_busy  <= (w_state_n == ST_SETTLE) || (w_state_n == ST_CHECK);
            r_done  <= (w_state_n == ST_DONE);
        end
    end

    assign dut_x            = r_x;
    assign busy             = r_busy;
    assign done             = r_done;
    assign pass             = r_pass;
    assign err_count        = r_err;
    assign first_fail_x     = r_ff;
    assign first_fail_valid = r_ffv;

endmodule
